// File: rtl/branch_predictor_pkg.sv
// Shared types for the ToastCore branch predictor: 2-bit counter encodings and the BTB entry layout.
package branch_predictor_pkg;

  localparam int BP_TAG_MAX_W = 30;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt2_e;

  // Tags are stored zero-extended to the widest possible tag so the layout is parameter-independent.
  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter with parallel load; resets to weak-not-taken.
module bp_sat_counter #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] RST_VAL = W'((1 << (W-1)) - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, zero-latency lookup,
// EX-stage training, global flush and saturating branch/mispredict performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [31:0]       IF_PC,
  output logic              IF_Pred_Taken,
  output logic [31:0]       IF_Pred_Target,
  input  logic              EX_Update,
  input  logic [31:0]       EX_PC,
  input  logic              EX_Taken,
  input  logic [31:0]       EX_Target,
  input  logic              EX_Mispredict,
  input  logic              Pred_Flush,
  output logic [PERF_W-1:0] Branch_Count,
  output logic [PERF_W-1:0] Mispredict_Count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(1 << (CNT_W-1));

  bp_entry_t         r_entry [ENTRIES];
  logic [CNT_W-1:0]  w_cnt   [ENTRIES];
  logic [PERF_W-1:0] r_branch_cnt;
  logic [PERF_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_if_hit;
  logic              w_ex_hit;
  logic              w_train;
  logic              w_unused_pc;

  assign w_if_idx = IF_PC[IDX_W+1:2];
  assign w_if_tag = IF_PC[31:IDX_W+2];
  assign w_ex_idx = EX_PC[IDX_W+1:2];
  assign w_ex_tag = EX_PC[31:IDX_W+2];
  assign w_unused_pc = ^{IF_PC[1:0], EX_PC[1:0]};

  assign w_if_hit = r_entry[w_if_idx].valid &&
                    (r_entry[w_if_idx].tag == BP_TAG_MAX_W'(w_if_tag));
  assign w_ex_hit = r_entry[w_ex_idx].valid &&
                    (r_entry[w_ex_idx].tag == BP_TAG_MAX_W'(w_ex_tag));

  // Lookup reads registered state only, so a same-cycle update is not visible until the next cycle.
  assign IF_Pred_Taken  = w_if_hit && w_cnt[w_if_idx][CNT_W-1];
  assign IF_Pred_Target = w_if_hit ? r_entry[w_if_idx].target : 32'h0;

  // A flush in the same cycle suppresses training entirely.
  assign w_train = EX_Update && !Pred_Flush;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entry[i] <= '0;
      end
    end else if (Pred_Flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entry[i].valid <= 1'b0;
      end
    end else if (EX_Update && EX_Taken) begin
      if (w_ex_hit) begin
        r_entry[w_ex_idx].target <= EX_Target;
      end else begin
        r_entry[w_ex_idx].valid  <= 1'b1;
        r_entry[w_ex_idx].tag    <= BP_TAG_MAX_W'(w_ex_tag);
        r_entry[w_ex_idx].target <= EX_Target;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    logic w_sel;
    assign w_sel = w_train && (w_ex_idx == IDX_W'(g));

    bp_sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .i_inc      (w_sel && w_ex_hit && EX_Taken),
      .i_dec      (w_sel && w_ex_hit && !EX_Taken),
      .i_load     (w_sel && !w_ex_hit && EX_Taken),
      .i_load_val (CNT_WEAK_TAKEN),
      .o_cnt      (w_cnt[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (EX_Update && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + PERF_W'(1);
      end
      if (EX_Update && EX_Mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + PERF_W'(1);
      end
    end
  end

  assign Branch_Count     = r_branch_cnt;
  assign Mispredict_Count = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, hand sequences for perf/async reset, random vs. model.
module tb_branch_predictor;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] IF_PC = '0;
  logic        EX_Update = 1'b0;
  logic [31:0] EX_PC = '0;
  logic        EX_Taken = 1'b0;
  logic [31:0] EX_Target = '0;
  logic        EX_Mispredict = 1'b0;
  logic        Pred_Flush = 1'b0;

  logic        pred_tk;
  logic [31:0] pred_tgt;
  logic [31:0] br_cnt, mp_cnt;
  logic        p3_unused_tk;
  logic [31:0] p3_unused_tgt;
  logic [2:0]  br3_cnt, mp3_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .PERF_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .IF_PC(IF_PC),
    .IF_Pred_Taken(pred_tk), .IF_Pred_Target(pred_tgt),
    .EX_Update(EX_Update), .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_Mispredict(EX_Mispredict), .Pred_Flush(Pred_Flush),
    .Branch_Count(br_cnt), .Mispredict_Count(mp_cnt)
  );

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .PERF_W(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .IF_PC(IF_PC),
    .IF_Pred_Taken(p3_unused_tk), .IF_Pred_Target(p3_unused_tgt),
    .EX_Update(EX_Update), .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_Mispredict(EX_Mispredict), .Pred_Flush(Pred_Flush),
    .Branch_Count(br3_cnt), .Mispredict_Count(mp3_cnt)
  );

  typedef struct {
    bit          upd;
    logic [31:0] ex_pc;
    bit          tk;
    logic [31:0] tgt;
    bit          mp;
    bit          fl;
    logic [31:0] if_pc;
    bit          e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl[20];

  // Behavioural reference: 16-entry table, counters as plain integers 0..3, taken when >= 2.
  bit          m_v[16];
  logic [25:0] m_tag[16];
  logic [31:0] m_tgt[16];
  int          m_cnt[16];
  longint      m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(bit upd, logic [31:0] ex_pc, bit tk, logic [31:0] tgt, bit mp,
                              bit fl, logic [31:0] if_pc, bit e_tk, logic [31:0] e_tgt);
    vec_t v;
    v.upd = upd; v.ex_pc = ex_pc; v.tk = tk; v.tgt = tgt; v.mp = mp;
    v.fl = fl; v.if_pc = if_pc; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic drive(input bit upd, input logic [31:0] expc, input bit tk, input logic [31:0] tgt,
                       input bit mp, input bit fl, input logic [31:0] ifpc);
    @(negedge Clk);
    EX_Update = upd; EX_PC = expc; EX_Taken = tk; EX_Target = tgt;
    EX_Mispredict = mp; Pred_Flush = fl; IF_PC = ifpc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    EX_Update = 0; EX_PC = '0; EX_Taken = 0; EX_Target = '0;
    EX_Mispredict = 0; Pred_Flush = 0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic model_step();
    int idx;
    logic [25:0] tag;
    bit hit;
    if (EX_Update) begin
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (EX_Mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    if (Pred_Flush) begin
      for (int i = 0; i < 16; i++) m_v[i] = 0;
    end else if (EX_Update) begin
      idx = int'((EX_PC >> 2) & 32'hF);
      tag = EX_PC[31:6];
      hit = m_v[idx] && (m_tag[idx] == tag);
      if (hit && EX_Taken) begin
        m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
        m_tgt[idx] = EX_Target;
      end else if (hit) begin
        m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
      end else if (EX_Taken) begin
        m_v[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = EX_Target; m_cnt[idx] = 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [25:0] t;
    logic [3:0]  i;
    logic [1:0]  lo;
    t  = 26'($urandom_range(0, 3));
    if (t == 26'd3) t = 26'h3FF_FFFF;
    i  = 4'($urandom_range(0, 15));
    lo = 2'($urandom_range(0, 3));
    return {t, i, lo};
  endfunction

  initial begin
    int idx;
    bit hit;

    tbl[0]  = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h20,   0, 32'h0);
    tbl[1]  = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h1000, 0, 32'h0);
    tbl[2]  = mk(1, 32'h20, 1, 32'h30, 1, 0, 32'h20,   0, 32'h0);
    tbl[3]  = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h20,   1, 32'h30);
    tbl[4]  = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h60,   0, 32'h0);
    tbl[5]  = mk(1, 32'h20, 0, 32'h0,  1, 0, 32'h20,   1, 32'h30);
    tbl[6]  = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h20,   0, 32'h30);
    tbl[7]  = mk(1, 32'h20, 1, 32'h30, 0, 0, 32'h20,   0, 32'h30);
    tbl[8]  = mk(1, 32'h20, 1, 32'h30, 0, 0, 32'h20,   1, 32'h30);
    tbl[9]  = mk(1, 32'h20, 1, 32'h30, 0, 0, 32'h20,   1, 32'h30);
    tbl[10] = mk(1, 32'h20, 1, 32'h30, 0, 0, 32'h20,   1, 32'h30);
    tbl[11] = mk(1, 32'h20, 0, 32'h0,  1, 0, 32'h20,   1, 32'h30);
    tbl[12] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h20,   1, 32'h30);
    tbl[13] = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h40,   0, 32'h0);
    tbl[14] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h40,   0, 32'h0);
    tbl[15] = mk(1, 32'h40, 0, 32'h0,  0, 0, 32'h40,   0, 32'h0);
    tbl[16] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h43,   0, 32'h0);
    tbl[17] = mk(1, 32'h80, 1, 32'h90, 0, 1, 32'h20,   1, 32'h30);
    tbl[18] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h20,   0, 32'h0);
    tbl[19] = mk(0, 32'h0,  0, 32'h0,  0, 0, 32'h80,   0, 32'h0);

    IF_PC = 32'h20;
    #1;
    chk("reset_taken_async", {31'b0, pred_tk}, 32'h0);
    do_reset();
    #1;
    chk("reset_br_cnt", br_cnt, 32'h0);
    chk("reset_mp_cnt", mp_cnt, 32'h0);

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].upd, tbl[r].ex_pc, tbl[r].tk, tbl[r].tgt, tbl[r].mp, tbl[r].fl, tbl[r].if_pc);
      #1;
      chk($sformatf("vec%0d_taken", r), {31'b0, pred_tk}, {31'b0, tbl[r].e_tk});
      chk($sformatf("vec%0d_target", r), pred_tgt, tbl[r].e_tgt);
    end
    chk("tbl_br_cnt", br_cnt, 32'd10);
    chk("tbl_mp_cnt", mp_cnt, 32'd3);
    chk("tbl_br_cnt_w3", {29'b0, br3_cnt}, 32'd7);
    chk("tbl_mp_cnt_w3", {29'b0, mp3_cnt}, 32'd3);

    // Perf counters: 5 updates with 2 mispredicts, then 4 more to saturate the 3-bit instance.
    do_reset();
    for (int k = 0; k < 5; k++) drive(1, 32'h100, 1, 32'h104, (k == 1 || k == 3), 0, 32'h100);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h100);
    #1;
    chk("perf5_br", br_cnt, 32'd5);
    chk("perf5_mp", mp_cnt, 32'd2);
    chk("perf5_br_w3", {29'b0, br3_cnt}, 32'd5);
    for (int k = 0; k < 4; k++) drive(1, 32'h100, 1, 32'h104, 0, 0, 32'h100);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h100);
    #1;
    chk("perf9_br", br_cnt, 32'd9);
    chk("perf9_br_w3_sat", {29'b0, br3_cnt}, 32'd7);
    chk("perf9_mp_w3", {29'b0, mp3_cnt}, 32'd2);
    chk("pre_areset_taken", {31'b0, pred_tk}, 32'h1);
    chk("pre_areset_target", pred_tgt, 32'h104);

    // Asynchronous reset between clock edges.
    #2;
    Reset_n = 1'b0;
    #1;
    chk("areset_taken", {31'b0, pred_tk}, 32'h0);
    chk("areset_target", pred_tgt, 32'h0);
    chk("areset_br", br_cnt, 32'h0);
    chk("areset_mp", mp_cnt, 32'h0);
    chk("areset_br_w3", {29'b0, br3_cnt}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk("post_areset_miss_taken", {31'b0, pred_tk}, 32'h0);
    chk("post_areset_miss_target", pred_tgt, 32'h0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 7), rand_pc(), $urandom_range(0, 1) == 1, $urandom(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, rand_pc());
      #1;
      idx = int'((IF_PC >> 2) & 32'hF);
      hit = m_v[idx] && (m_tag[idx] == IF_PC[31:6]);
      chk("rand_taken", {31'b0, pred_tk}, {31'b0, hit && (m_cnt[idx] >= 2)});
      chk("rand_target", pred_tgt, hit ? m_tgt[idx] : 32'h0);
      chk("rand_br", br_cnt, 32'(m_bc));
      chk("rand_mp", mp_cnt, 32'(m_mc));
      chk("rand_br_w3", {29'b0, br3_cnt}, (m_bc > 7) ? 32'd7 : 32'(m_bc));
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
